dice_roller: RTL and testbench



---
 rtl/dice_roller.sv | 115 +++++++++++
 tb/tb_dice_roller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// Electronic die: animates the face while the roll button is held, then draws
// an unbiased 1..6 from the LFSR byte by rejection sampling on the low three
// bits, falling back to a full-byte modulo after too many rejects.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | holding the last result (or 1 after reset), waiting for roll edge
// ROLL  | animating face, counting steps, waiting for release + min steps
// DRAW  | sampling rnd until the low bits give 1..6 or rejects run out
module dice_roller #(
  parameter int ANIM_DIV   = 4,
  parameter int MIN_ROLL   = 8,
  parameter int MAX_REJECT = 8
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic [7:0] rnd,
  input  logic       roll,
  output logic [2:0] face,
  output logic [6:0] pips,
  output logic       valid,
  output logic       done,
  output logic       busy
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ROLL, DRAW} state_t;

  state_t           state;
  logic             roll_q;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       step_cnt;
  logic [3:0]       reject_cnt;

  logic       roll_rise;
  logic [2:0] r_low;
  logic       r_ok;
  logic [2:0] face_mod;

  assign roll_rise = roll & ~roll_q;
  assign r_low     = rnd[2:0];
  assign r_ok      = (r_low != 3'd0) && (r_low != 3'd7);
  // Fallback uses the whole byte; slightly biased but bounds draw latency.
  assign face_mod  = 3'(rnd % 8'd6) + 3'd1;

  // Sequencer: edge detect, animation timing, rejection sampling, commit.
  always_ff @(posedge Clk) begin
    if (rst) begin
      state      <= IDLE;
      face       <= 3'd1;
      valid      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      roll_q     <= 1'b0;
      div_cnt    <= '0;
      step_cnt   <= '0;
      reject_cnt <= '0;
    end else begin
      roll_q <= roll;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (roll_rise) begin
            state    <= ROLL;
            valid    <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
            step_cnt <= '0;
          end
        end
        ROLL: begin
          if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
            div_cnt <= '0;
            face    <= (face == 3'd6) ? 3'd1 : face + 3'd1;
            if (step_cnt != 8'hFF) step_cnt <= step_cnt + 8'd1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (!roll && (step_cnt >= 8'(MIN_ROLL))) begin
            state      <= DRAW;
            reject_cnt <= '0;
          end
        end
        DRAW: begin
          if (r_ok || (reject_cnt == 4'(MAX_REJECT - 1))) begin
            face  <= r_ok ? r_low : face_mod;
            valid <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            reject_cnt <= reject_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Board pip pattern decoded straight from the face register.
  always_comb begin
    pips = 7'b0000000;
    case (face)
      3'd1: pips = 7'b0000001;
      3'd2: pips = 7'b1000010;
      3'd3: pips = 7'b1000011;
      3'd4: pips = 7'b1100110;
      3'd5: pips = 7'b1100111;
      3'd6: pips = 7'b1111110;
      default: pips = 7'b0000000;
    endcase
  end

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller: directed scenarios plus randomized rolls
// checked cycle by cycle against a closed-form roll/draw model.
module tb_dice_roller;

  localparam int ANIM_DIV   = 4;
  localparam int MIN_ROLL   = 8;
  localparam int MAX_REJECT = 8;

  logic       Clk;
  logic       rst;
  logic [7:0] rnd;
  logic       roll;
  logic [2:0] face;
  logic [6:0] pips;
  logic       valid;
  logic       done;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cur_face = 1;
  logic [7:0] rv [0:255];

  dice_roller #(
    .ANIM_DIV(ANIM_DIV),
    .MIN_ROLL(MIN_ROLL),
    .MAX_REJECT(MAX_REJECT)
  ) dut (
    .Clk(Clk),
    .rst(rst),
    .rnd(rnd),
    .roll(roll),
    .face(face),
    .pips(pips),
    .valid(valid),
    .done(done),
    .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pips_of(input int f);
    case (f)
      1: return 7'b0000001;
      2: return 7'b1000010;
      3: return 7'b1000011;
      4: return 7'b1100110;
      5: return 7'b1100111;
      6: return 7'b1111110;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int adv(input int f, input int k);
    return ((f - 1 + k) % 6) + 1;
  endfunction

  // Edge (counted from the roll-rise edge 0) on which ROLL hands over to DRAW.
  function automatic int exit_edge(input int h);
    int m;
    m = MIN_ROLL * ANIM_DIV + 1;
    return (h > m) ? h : m;
  endfunction

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 256; i++) rv[i] = v;
  endtask

  // mode 0: uniform bytes; 1: mostly rejected low bits; 2: always rejected
  task automatic fill_random(input int mode);
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      if (mode == 2 || (mode == 1 && $urandom_range(0, 3) != 0))
        b[2:0] = ($urandom_range(0, 1) != 0) ? 3'd7 : 3'd0;
      rv[i] = b;
    end
  endtask

  task automatic check_outputs(input string tag, input int ef, input bit ev,
                               input bit ed, input bit eb);
    check_eq({tag, "_st"}, {28'd0, valid, done, busy, face},
             {28'd0, ev, ed, eb, 3'(ef)});
    check_eq({tag, "_pips"}, {25'd0, pips}, {25'd0, pips_of(ef)});
  endtask

  // One roll: button high for h edges starting at edge 0, rnd from rv[].
  task automatic run_trial(input string name, input int h, input bit extra_pulse);
    int x, c, drawn, ef;
    bit found;
    x = exit_edge(h);
    c = 0;
    drawn = 0;
    found = 1'b0;
    for (int j = 0; j < MAX_REJECT; j++) begin
      if (!found) begin
        if (rv[x+1+j][2:0] >= 3'd1 && rv[x+1+j][2:0] <= 3'd6) begin
          drawn = int'(rv[x+1+j][2:0]);
          c = x + 1 + j;
          found = 1'b1;
        end else if (j == MAX_REJECT - 1) begin
          drawn = (int'(rv[x+1+j]) % 6) + 1;
          c = x + 1 + j;
          found = 1'b1;
        end
      end
    end
    for (int i = 0; i <= c + 1; i++) begin
      roll = (i < h) || (extra_pulse && i == x + 1);
      rnd  = rv[i];
      @(posedge Clk);
      #1;
      if (i <= x) begin
        ef = adv(cur_face, i / ANIM_DIV);
        check_outputs($sformatf("%s_roll%0d", name, i), ef, 1'b0, 1'b0, 1'b1);
      end else if (i < c) begin
        ef = adv(cur_face, x / ANIM_DIV);
        check_outputs($sformatf("%s_draw%0d", name, i), ef, 1'b0, 1'b0, 1'b1);
      end else if (i == c) begin
        check_outputs($sformatf("%s_commit", name), drawn, 1'b1, 1'b1, 1'b0);
      end else begin
        check_outputs($sformatf("%s_after", name), drawn, 1'b1, 1'b0, 1'b0);
      end
    end
    cur_face = drawn;
    roll = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rnd = 8'($urandom);
      @(posedge Clk);
      #1;
      check_outputs($sformatf("%s_idle%0d", name, i), cur_face, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int x;
    rst  = 1'b1;
    roll = 1'b0;
    rnd  = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    check_outputs("reset", 1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic roll: constant rnd 0x05 draws 5 on the first DRAW cycle.
    fill_const(8'h05);
    run_trial("basic", 1, 1'b0);
    check_eq("basic_face", {29'd0, face}, 32'd5);

    // Rejection: three rejected samples, then 0x02.
    fill_const(8'h05);
    x = exit_edge(1);
    rv[x+1] = 8'h07;
    rv[x+2] = 8'h00;
    rv[x+3] = 8'hF8;
    rv[x+4] = 8'h02;
    run_trial("reject", 1, 1'b0);
    check_eq("reject_face", {29'd0, face}, 32'd2);

    // Fallback: every sample rejected, 255 mod 6 + 1 = 4.
    fill_const(8'hFF);
    run_trial("fallback", 3, 1'b0);
    check_eq("fallback_face", {29'd0, face}, 32'd4);

    // Held button for 100 cycles with a stray roll pulse during DRAW.
    fill_random(0);
    run_trial("held", 100, 1'b1);

    // Reset mid-ROLL at animation step 5; button stays high through reset.
    roll = 1'b1;
    rnd  = 8'h00;
    for (int i = 0; i <= 5 * ANIM_DIV; i++) begin
      @(posedge Clk);
      #1;
    end
    check_outputs("midroll_pre", adv(cur_face, 5), 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #3;
    check_outputs("rst_between_edges", adv(cur_face, 5), 1'b0, 1'b0, 1'b1);
    @(posedge Clk);
    #1;
    check_outputs("midroll_rst", 1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cur_face = 1;
    fill_random(0);
    run_trial("restart", 2, 1'b0);

    // Randomized rolls.
    for (int t = 0; t < 16; t++) begin
      fill_random($urandom_range(0, 2));
      run_trial($sformatf("rand%0d", t), $urandom_range(1, 60), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
